// File: rtl/common_enums.sv
`timescale 1ns/1ps
`default_nettype none
// common_enums: shared screen, player and chess-clock state types, plus the
// mode_sel-to-initial-time table used by the clock and the display counter.
package common_enums;

    typedef enum logic [2:0] {
        SETUP_SCREEN  = 3'd0,
        CHESS_SCREEN  = 3'd1,
        RESULT_SCREEN = 3'd2,
        MENU_SCREEN   = 3'd3
    } screen_state_t;

    typedef enum logic {
        WHITE = 1'b0,
        BLACK = 1'b1
    } player_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        PAUSED  = 3'd3,
        EXPIRED = 3'd4
    } clk_state_t;

    localparam int CS_W = 18;

    function automatic logic [CS_W-1:0] init_time(input logic [1:0] sel);
        logic [CS_W-1:0] t;
        case (sel)
            2'd0:    t = 18'd6000;
            2'd1:    t = 18'd18000;
            2'd2:    t = 18'd60000;
            default: t = 18'd180000;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chess_clock_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// chess_clock_ctrl_if: control inputs from the screen FSM / move logic and
// the time outputs consumed by the displays.
interface chess_clock_ctrl_if;
    common_enums::screen_state_t state;
    logic [1:0]                  mode_sel;
    logic                        move_done;
    logic                        pause;
    common_enums::player_t       active_player;
    logic [17:0]                 white_cs;
    logic [17:0]                 black_cs;
    logic [17:0]                 active_cs;
    logic                        running;
    logic                        flag_fall;
    common_enums::player_t       loser;

    modport master (
        output state, mode_sel, move_done, pause,
        input  active_player, white_cs, black_cs, active_cs, running, flag_fall, loser
    );

    modport slave (
        input  state, mode_sel, move_done, pause,
        output active_player, white_cs, black_cs, active_cs, running, flag_fall, loser
    );
endinterface
`default_nettype wire

// File: rtl/tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// tick_gen: divide-by-DIV counter with synchronous clear and enable; tick is
// high for the one cycle in which the enabled counter sits at DIV-1.
module tick_gen #(
    parameter int DIV = 500_000
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic clear,
    input  wire logic enable,
    output logic      tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);
endmodule
`default_nettype wire

// File: rtl/chess_clock_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// chess_clock_ctrl: turn-sequenced two-player chess clock with per-move
// increment, pause, and sticky flag-fall detection.
module chess_clock_ctrl
    import common_enums::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int INC_CS      = 0
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    chess_clock_ctrl_if.slave    bus
);
    localparam int DIV = CLK_FREQ_HZ / 100;

    clk_state_t      cur_state, nxt_state;
    logic [CS_W-1:0] white_reg, black_reg, nxt_white, nxt_black;
    player_t         active_reg, nxt_active, loser_reg, nxt_loser;
    logic            flag_reg, nxt_flag, running_reg;

    logic            in_chess, tick, div_clear, div_en;
    logic [CS_W-1:0] init_cs, mover_cs, dec_cs, inc_cs;
    logic [CS_W:0]   inc_sum;

    assign in_chess = (bus.state == CHESS_SCREEN);
    assign init_cs  = init_time(bus.mode_sel);
    assign div_en   = (cur_state == RUN) && in_chess && !bus.pause;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (div_clear),
        .enable  (div_en),
        .tick    (tick)
    );

    // A tick coinciding with a move is charged to the mover before the increment.
    assign mover_cs = (active_reg == BLACK) ? black_reg : white_reg;
    assign dec_cs   = tick ? (mover_cs - 1'b1) : mover_cs;
    assign inc_sum  = {1'b0, dec_cs} + (CS_W+1)'(INC_CS);
    assign inc_cs   = inc_sum[CS_W] ? {CS_W{1'b1}} : inc_sum[CS_W-1:0];

    always_comb begin
        nxt_state  = cur_state;
        nxt_white  = white_reg;
        nxt_black  = black_reg;
        nxt_active = active_reg;
        nxt_flag   = flag_reg;
        nxt_loser  = loser_reg;
        div_clear  = 1'b0;

        if (cur_state != IDLE && !in_chess) begin
            nxt_state  = IDLE;
            nxt_white  = init_cs;
            nxt_black  = init_cs;
            nxt_active = WHITE;
            nxt_flag   = 1'b0;
        end else begin
            case (cur_state)
                IDLE: begin
                    nxt_white  = init_cs;
                    nxt_black  = init_cs;
                    nxt_active = WHITE;
                    nxt_flag   = 1'b0;
                    if (in_chess) nxt_state = LOAD;
                end
                LOAD: begin
                    nxt_white  = init_cs;
                    nxt_black  = init_cs;
                    nxt_active = WHITE;
                    div_clear  = 1'b1;
                    nxt_state  = RUN;
                end
                RUN: begin
                    if (bus.pause) begin
                        nxt_state = PAUSED;
                    end else if (tick && dec_cs == '0) begin
                        nxt_state = EXPIRED;
                        nxt_flag  = 1'b1;
                        nxt_loser = active_reg;
                        if (active_reg == BLACK) nxt_black = '0;
                        else                     nxt_white = '0;
                    end else if (bus.move_done) begin
                        if (active_reg == BLACK) nxt_black = inc_cs;
                        else                     nxt_white = inc_cs;
                        nxt_active = (active_reg == WHITE) ? BLACK : WHITE;
                        div_clear  = 1'b1;
                    end else if (tick) begin
                        if (active_reg == BLACK) nxt_black = dec_cs;
                        else                     nxt_white = dec_cs;
                    end
                end
                PAUSED: begin
                    if (!bus.pause) nxt_state = RUN;
                end
                EXPIRED: begin
                    nxt_state = EXPIRED;
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state   <= IDLE;
            white_reg   <= '0;
            black_reg   <= '0;
            active_reg  <= WHITE;
            loser_reg   <= WHITE;
            flag_reg    <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            white_reg   <= nxt_white;
            black_reg   <= nxt_black;
            active_reg  <= nxt_active;
            loser_reg   <= nxt_loser;
            flag_reg    <= nxt_flag;
            running_reg <= (nxt_state == RUN);
        end
    end

    assign bus.white_cs      = white_reg;
    assign bus.black_cs      = black_reg;
    assign bus.active_player = active_reg;
    assign bus.active_cs     = (active_reg == BLACK) ? black_reg : white_reg;
    assign bus.running       = running_reg;
    assign bus.flag_fall     = flag_reg;
    assign bus.loser         = loser_reg;
endmodule
`default_nettype wire
